// File: rtl/csa_accum_ctrl_pkg.sv
// Shared definitions for the carry-save accumulation sequencer: state encoding,
// default geometry and the resolve-chunk derivations.
package csa_accum_ctrl_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int GUARD_DEF = 8;
    localparam int CHUNK_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic int calc_nchunk(input int width, input int guard, input int chunk);
        return (width + guard) / chunk;
    endfunction

    function automatic int calc_idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/csa_row_3to2.sv
// W-bit 3:2 carry-save compressor; the carry vector is returned unshifted so the
// caller decides how to align and truncate it.
module csa_row_3to2 #(
    parameter int W = 40
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand signed accumulator: keeps the total in sum/carry form while
// operands stream in, then resolves it to binary one CHUNK-bit slice per cycle.
module csa_accum_ctrl
    import csa_accum_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int GUARD = GUARD_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_of,
    output logic [GUARD:0]   out_count,
    output logic             busy
);

    localparam int W      = WIDTH + GUARD;
    localparam int NCHUNK = calc_nchunk(WIDTH, GUARD, CHUNK);
    localparam int KW     = calc_idx_width(NCHUNK);
    localparam logic [GUARD:0] MAX_COUNT = {1'b1, {GUARD{1'b0}}};
    localparam logic [KW-1:0]  LAST_K    = KW'(NCHUNK - 1);

    state_t           r_state, w_state_next;
    logic [W-1:0]     r_s, r_c, r_res;
    logic [GUARD:0]   r_count;
    logic [KW-1:0]    r_k;
    logic             r_cy;
    logic             r_out_valid, r_out_cout, r_out_of;
    logic [WIDTH-1:0] r_out_sum;
    logic [GUARD:0]   r_out_count;

    logic [W-1:0]     w_x, w_csa_sum, w_csa_carry, w_res_next;
    logic [GUARD:0]   w_count_next;
    logic [CHUNK:0]   w_chunk_add;
    logic [W-WIDTH:0] w_res_hi;
    logic             w_accept, w_last, w_last_chunk;

    assign in_ready     = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign busy         = (r_state != ST_IDLE);
    assign w_accept     = in_valid & in_ready;
    assign w_x          = {{GUARD{in_data[WIDTH-1]}}, in_data};
    assign w_count_next = r_count + (GUARD+1)'(1);
    assign w_last       = in_last || (w_count_next == MAX_COUNT);
    assign w_last_chunk = (r_k == LAST_K);

    csa_row_3to2 #(.W(W)) u_row (
        .i_a     (r_s),
        .i_b     (r_c),
        .i_c     (w_x),
        .o_sum   (w_csa_sum),
        .o_carry (w_csa_carry)
    );

    // One ripple slice of the final sum+carry resolution, merged into the result.
    always_comb begin
        w_chunk_add = {1'b0, r_s[r_k*CHUNK +: CHUNK]} + {1'b0, r_c[r_k*CHUNK +: CHUNK]}
                    + (CHUNK+1)'(r_cy);
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_res_next = r_res;
        w_res_next[r_k*CHUNK +: CHUNK] = w_chunk_add[CHUNK-1:0];
        w_res_hi = w_res_next[W-1:WIDTH-1];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_ACCUM: if (w_accept) w_state_next = w_last ? ST_RESOLVE : ST_ACCUM;
            ST_RESOLVE:        if (w_last_chunk) w_state_next = ST_DONE;
            ST_DONE:           if (out_ready) w_state_next = ST_IDLE;
            default:           w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_count     <= '0;
            r_k         <= '0;
            r_cy        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_of    <= 1'b0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        r_s     <= w_csa_sum;
                        r_c     <= w_csa_carry << 1;  // top carry falls off: mod 2**W
                        r_count <= w_count_next;
                        r_k     <= '0;
                        r_cy    <= 1'b0;
                    end
                end
                ST_RESOLVE: begin
                    r_res <= w_res_next;
                    r_cy  <= w_chunk_add[CHUNK];
                    r_k   <= r_k + KW'(1);
                    if (w_last_chunk) begin
                        r_k         <= '0;
                        r_out_valid <= 1'b1;
                        r_out_sum   <= w_res_next[WIDTH-1:0];
                        r_out_cout  <= w_res_next[WIDTH];
                        r_out_of    <= !((&w_res_hi) || !(|w_res_hi));
                        r_out_count <= r_count;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_s         <= '0;
                        r_c         <= '0;
                        r_res       <= '0;
                        r_count     <= '0;
                        r_k         <= '0;
                        r_cy        <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_sum   <= '0;
                        r_out_cout  <= 1'b0;
                        r_out_of    <= 1'b0;
                        r_out_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cout  = r_out_cout;
    assign out_of    = r_out_of;
    assign out_count = r_out_count;

endmodule
